// File: rtl/rename_ckpt_unit_pkg.sv
// Shared types for the rename stage: uop payload, map snapshot, checkpoint record.
// Also provides the identity map used at reset.
package rename_ckpt_unit_pkg;

  localparam int P_NUM_AREG = 32;
  localparam int P_NUM_PREG = 128;
  localparam int P_NUM_CKPT = 4;
  localparam int P_TAG_W    = 4;
  localparam int P_PREG_W   = $clog2(P_NUM_PREG);

  typedef struct packed {
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [2:0]  fu_sel;
  } uop_payload_t;

  typedef logic [P_NUM_AREG-1:0][P_PREG_W-1:0] map_t;

  typedef struct packed {
    logic               valid;
    logic [P_TAG_W-1:0] tag;
    map_t               map;
    logic [P_PREG_W-1:0] rptr;
    logic [P_TAG_W-1:0] tag_next;
  } ckpt_t;

  function automatic map_t reset_map();
    map_t m;
    for (int i = 0; i < P_NUM_AREG; i++) m[i] = P_PREG_W'(i);
    return m;
  endfunction

endpackage

// File: rtl/rename_free_fifo.sv
// Circular free list of physical registers; the read pointer can be rewound
// in one cycle on mispredict recovery. A full flag disambiguates wptr == rptr.
module rename_free_fifo
  import rename_ckpt_unit_pkg::*;
#(
  parameter int NUM_PREG = P_NUM_PREG,
  parameter int NUM_AREG = P_NUM_AREG,
  localparam int PREG_W  = $clog2(NUM_PREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pop,
  input  logic              i_push,
  input  logic [PREG_W-1:0] i_push_data,
  input  logic              i_restore_en,
  input  logic [PREG_W-1:0] i_restore_rptr,
  output logic [PREG_W-1:0] o_head,
  output logic [PREG_W-1:0] o_rptr,
  output logic              o_empty
);

  logic [PREG_W-1:0] r_list [NUM_PREG];
  logic [PREG_W-1:0] r_rptr, r_wptr;
  logic              r_full;
  logic [PREG_W-1:0] w_rptr_n, w_wptr_n;
  logic              w_full_n;

  assign o_head  = r_list[r_rptr];
  assign o_rptr  = r_rptr;
  assign o_empty = (r_wptr == r_rptr) && !r_full;

  // Restore only rewinds the read pointer, so the occupancy can only grow.
  always_comb begin
    w_rptr_n = i_restore_en ? i_restore_rptr : (r_rptr + PREG_W'(i_pop));
    w_wptr_n = r_wptr + PREG_W'(i_push);
    w_full_n = 1'b0;
    if (w_wptr_n == w_rptr_n) begin
      if (i_restore_en)
        w_full_n = r_full || i_push || (i_restore_rptr != r_rptr);
      else if (i_push && !i_pop)
        w_full_n = 1'b1;
      else if (i_pop && !i_push)
        w_full_n = 1'b0;
      else
        w_full_n = r_full;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREG; i++)
        r_list[i] <= (i < NUM_PREG - NUM_AREG) ? PREG_W'(NUM_AREG + i) : '0;
      r_rptr <= '0;
      r_wptr <= PREG_W'(NUM_PREG - NUM_AREG);
      r_full <= 1'b0;
    end else begin
      if (i_push) r_list[r_wptr] <= i_push_data;
      r_rptr <= w_rptr_n;
      r_wptr <= w_wptr_n;
      r_full <= w_full_n;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(i_push && r_full && !i_pop));

endmodule

// File: rtl/rename_ckpt_unit.sv
// Single-wide rename stage: map table, ROB tag allocation and branch checkpoints
// with one-cycle recovery. Define RENAME_PERF_CNT_EN to add stall/flush counters.
module rename_ckpt_unit
  import rename_ckpt_unit_pkg::*;
#(
  parameter int NUM_AREG = P_NUM_AREG,
  parameter int NUM_PREG = P_NUM_PREG,
  parameter int NUM_CKPT = P_NUM_CKPT,
  parameter int TAG_W    = P_TAG_W,
  localparam int AREG_W  = $clog2(NUM_AREG),
  localparam int PREG_W  = $clog2(NUM_PREG),
  localparam int CKPT_W  = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [AREG_W-1:0] in_rs1,
  input  logic [AREG_W-1:0] in_rs2,
  input  logic [AREG_W-1:0] in_rd,
  input  logic              in_wr_rd,
  input  logic              in_ckpt,
  input  uop_payload_t      in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [PREG_W-1:0] out_ps1,
  output logic [PREG_W-1:0] out_ps2,
  output logic [PREG_W-1:0] out_pd_old,
  output logic [PREG_W-1:0] out_pd_new,
  output logic [TAG_W-1:0]  out_rob_tag,
  output logic [CKPT_W-1:0] out_ckpt_id,
  output uop_payload_t      out_payload,
  input  logic              free_valid,
  input  logic [PREG_W-1:0] free_preg,
  input  logic              resolve_valid,
  input  logic              resolve_mispredict,
  input  logic [TAG_W-1:0]  resolve_tag,
  output logic              ckpt_full,
  output logic              fl_empty
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_fl,
  output logic [31:0]       perf_stall_ckpt,
  output logic [31:0]       perf_flush
`endif
);

  ckpt_t               r_ckpt    [NUM_CKPT];
  logic [NUM_CKPT-1:0] r_younger [NUM_CKPT];  // r_younger[j][i]: slot i taken after slot j
  map_t                r_map;
  logic [TAG_W-1:0]    r_tag_ctr;

  map_t                w_map_post;
  logic                w_wr, w_accept, w_res_hit, w_flush, w_hit;
  logic [CKPT_W-1:0]   w_res_idx, w_free_idx;
  logic [NUM_CKPT-1:0] w_valid;
  logic [PREG_W-1:0]   w_fl_head, w_fl_rptr, w_rptr_post;

  assign w_wr      = in_wr_rd && (in_rd != '0);
  assign ckpt_full = &w_valid;
  assign in_ready  = (!out_valid || out_ready) && !(w_wr && fl_empty)
                   && !(in_ckpt && ckpt_full) && !(resolve_valid && resolve_mispredict);
  assign w_accept  = in_valid && in_ready;
  assign w_flush   = w_res_hit && resolve_mispredict;
  assign w_hit     = w_res_hit && !resolve_mispredict;
  assign w_rptr_post = w_fl_rptr + PREG_W'(w_wr);

  // Descending scans so the lowest matching / free slot wins.
  always_comb begin
    w_valid    = '0;
    w_res_hit  = 1'b0;
    w_res_idx  = '0;
    w_free_idx = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      w_valid[i] = r_ckpt[i].valid;
      if (!r_ckpt[i].valid) w_free_idx = CKPT_W'(i);
      if (resolve_valid && r_ckpt[i].valid && r_ckpt[i].tag == resolve_tag) begin
        w_res_hit = 1'b1;
        w_res_idx = CKPT_W'(i);
      end
    end
  end

  always_comb begin
    w_map_post = r_map;
    if (w_wr) w_map_post[in_rd] = w_fl_head;
  end

  rename_free_fifo #(.NUM_PREG(NUM_PREG), .NUM_AREG(NUM_AREG)) u_free_fifo (
    .clk            (clk),
    .reset          (reset),
    .i_pop          (w_accept && w_wr),
    .i_push         (free_valid && (free_preg != '0)),
    .i_push_data    (free_preg),
    .i_restore_en   (w_flush),
    .i_restore_rptr (r_ckpt[w_res_idx].rptr),
    .o_head         (w_fl_head),
    .o_rptr         (w_fl_rptr),
    .o_empty        (fl_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_map     <= reset_map();
      r_tag_ctr <= '0;
    end else if (w_flush) begin
      r_map     <= r_ckpt[w_res_idx].map;
      r_tag_ctr <= r_ckpt[w_res_idx].tag_next;
    end else if (w_accept) begin
      r_map     <= w_map_post;
      r_tag_ctr <= r_tag_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_ckpt[i]    <= '0;
        r_younger[i] <= '0;
      end
    end else begin
      if (w_accept && in_ckpt) begin
        r_ckpt[w_free_idx] <= '{valid: 1'b1, tag: r_tag_ctr, map: w_map_post,
                                rptr: w_rptr_post, tag_next: r_tag_ctr + 1'b1};
        r_younger[w_free_idx] <= '0;
        for (int j = 0; j < NUM_CKPT; j++)
          if (r_ckpt[j].valid) r_younger[j][w_free_idx] <= 1'b1;
      end
      if (w_hit) begin
        r_ckpt[w_res_idx].valid <= 1'b0;
        for (int j = 0; j < NUM_CKPT; j++) r_younger[j][w_res_idx] <= 1'b0;
      end
      if (w_flush) begin
        for (int j = 0; j < NUM_CKPT; j++)
          if (CKPT_W'(j) == w_res_idx || r_younger[w_res_idx][j])
            r_ckpt[j].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_ps1     <= '0;
      out_ps2     <= '0;
      out_pd_old  <= '0;
      out_pd_new  <= '0;
      out_rob_tag <= '0;
      out_ckpt_id <= '0;
      out_payload <= '0;
    end else if (w_flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_ps1     <= r_map[in_rs1];
      out_ps2     <= r_map[in_rs2];
      out_pd_old  <= r_map[in_rd];
      out_pd_new  <= w_wr ? w_fl_head : '0;
      out_rob_tag <= r_tag_ctr;
      out_ckpt_id <= in_ckpt ? w_free_idx : '0;
      out_payload <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_fl   <= '0;
      perf_stall_ckpt <= '0;
      perf_flush      <= '0;
    end else begin
      if (in_valid && !in_ready && w_wr && fl_empty && perf_stall_fl != '1)
        perf_stall_fl <= perf_stall_fl + 1'b1;
      if (in_valid && !in_ready && in_ckpt && ckpt_full && perf_stall_ckpt != '1)
        perf_stall_ckpt <= perf_stall_ckpt + 1'b1;
      if (w_flush && perf_flush != '1)
        perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule
